// File: rtl/inst_cache_nway.sv
// Set-associative instruction cache with word-serial line refill.
// Hits return in the same cycle; misses refill a whole line.
module inst_cache_nway #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int OFFSET_WIDTH = 6,
    parameter int INDEX_WIDTH  = 7,
    parameter int WAYS         = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  i_ce,
    input  logic [ADDR_WIDTH-1:0] i_address,
    input  logic                  i_flush,
    output logic                  o_ready,
    output logic                  o_mem_valid,
    output logic [ADDR_WIDTH-1:0] o_mem_address,
    input  logic                  i_mem_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_valid,
    output logic [ADDR_WIDTH-1:0] o_data_addr,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int TAG_WIDTH = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH;
    localparam int WW        = OFFSET_WIDTH - 2;
    localparam int SETS      = 1 << INDEX_WIDTH;
    localparam int WB        = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [1:0] {READY, REFILL, FLUSH} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [WB-1:0]           vic_q;
    logic [WW-1:0]           cnt_q;
    logic [INDEX_WIDTH-1:0]  fidx_q;
    logic                    pend_q;
    logic [WAYS-1:0]         valid_q [SETS];
    logic [WB-1:0]           rr_q    [SETS];

    logic [TAG_WIDTH-1:0]    a_tag, r_tag;
    logic [INDEX_WIDTH-1:0]  a_idx, r_idx;
    logic [WW-1:0]           a_off, r_off;
    logic                    req, flush_go, mem_wr, last;
    logic [WAYS-1:0]         hit_w;
    logic [WAYS-1:0][DATA_WIDTH-1:0] rd_w;
    logic                    hit;
    logic [DATA_WIDTH-1:0]   hit_data;
    logic [WB-1:0]           vic_d;
    logic                    found;

    assign a_tag = i_address[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign a_idx = i_address[OFFSET_WIDTH +: INDEX_WIDTH];
    assign a_off = i_address[2 +: WW];
    assign r_tag = addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];
    assign r_idx = addr_q[OFFSET_WIDTH +: INDEX_WIDTH];
    assign r_off = addr_q[2 +: WW];

    assign req      = (state_q == READY) && i_ce && !stall;
    assign flush_go = (state_q == READY) && (i_flush || pend_q);
    assign mem_wr   = (state_q == REFILL) && i_mem_valid;
    assign last     = mem_wr && (cnt_q == '1);

    // Per-way storage; line words are addressed as {set, word}.
    for (genvar w = 0; w < WAYS; w++) begin : g_way
        logic [DATA_WIDTH-1:0] mem_q [SETS << WW];
        logic [TAG_WIDTH-1:0]  tag_q [SETS];

        always_ff @(posedge clk) begin
            if (mem_wr && (vic_q == WB'(w))) begin
                mem_q[{r_idx, cnt_q}] <= i_mem_data;
                if (last) begin
                    tag_q[r_idx] <= r_tag;
                end
            end
        end

        assign hit_w[w] = valid_q[a_idx][w] && (tag_q[a_idx] == a_tag);
        assign rd_w[w]  = mem_q[{a_idx, a_off}];
    end

    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        vic_d    = rr_q[a_idx];
        found    = 1'b0;
        for (int i = 0; i < WAYS; i++) begin
            if (hit_w[i]) begin
                hit      = 1'b1;
                hit_data = rd_w[i];
            end
            if (!found && !valid_q[a_idx][i]) begin
                found = 1'b1;
                vic_d = WB'(i);
            end
        end
    end

    always_comb begin
        o_valid     = 1'b0;
        o_data      = hit_data;
        o_data_addr = i_address;
        if (state_q == REFILL) begin
            o_valid     = mem_wr && (cnt_q == r_off);
            o_data      = i_mem_data;
            o_data_addr = addr_q;
        end else if (req && !flush_go) begin
            o_valid = hit;
        end
    end

    assign o_ready       = (state_q == READY);
    assign o_mem_valid   = (state_q == REFILL);
    assign o_mem_address = {r_tag, r_idx, cnt_q, 2'b00};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= READY;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            fidx_q  <= '0;
            vic_q   <= '0;
            addr_q  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            unique case (state_q)
                READY: begin
                    if (flush_go) begin
                        pend_q  <= 1'b0;
                        fidx_q  <= '0;
                        state_q <= FLUSH;
                    end else if (req && !hit) begin
                        addr_q                <= i_address;
                        vic_q                 <= vic_d;
                        cnt_q                 <= '0;
                        valid_q[a_idx][vic_d] <= 1'b0;
                        state_q               <= REFILL;
                    end
                end
                REFILL: begin
                    if (i_flush) begin
                        pend_q <= 1'b1;
                    end
                    if (mem_wr) begin
                        cnt_q <= cnt_q + WW'(1);
                    end
                    if (last) begin
                        valid_q[r_idx][vic_q] <= 1'b1;
                        if (WAYS > 1) begin
                            rr_q[r_idx] <= rr_q[r_idx] + WB'(1);
                        end
                        state_q <= READY;
                    end
                end
                FLUSH: begin
                    if (i_flush) begin
                        pend_q <= 1'b1;
                    end
                    valid_q[fidx_q] <= '0;
                    fidx_q          <= fidx_q + INDEX_WIDTH'(1);
                    if (fidx_q == '1) begin
                        state_q <= READY;
                    end
                end
                default: state_q <= READY;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache_nway.sv
// Directed bench for inst_cache_nway: hit/miss table, eviction order,
// stall, flush and reset-during-refill sequences.
module tb_inst_cache_nway;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        i_ce;
    logic [31:0] i_address;
    logic        i_flush;
    logic        o_ready;
    logic        o_mem_valid;
    logic [31:0] o_mem_address;
    logic        i_mem_valid;
    logic [31:0] i_mem_data;
    logic        o_valid;
    logic [31:0] o_data_addr;
    logic [31:0] o_data;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 clk = ~clk;

    inst_cache_nway dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .i_ce         (i_ce),
        .i_address    (i_address),
        .i_flush      (i_flush),
        .o_ready      (o_ready),
        .o_mem_valid  (o_mem_valid),
        .o_mem_address(o_mem_address),
        .i_mem_valid  (i_mem_valid),
        .i_mem_data   (i_mem_data),
        .o_valid      (o_valid),
        .o_data_addr  (o_data_addr),
        .o_data       (o_data)
    );

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        string       name;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [31:0] mw(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One fetch; on a miss, plays memory for the whole line.
    task automatic fetch(input logic [31:0] a, input bit exp_hit,
                         input int flush_at, input int rst_at,
                         input string nm);
        logic [31:0] base;
        logic [31:0] wa;
        int          off;
        base = {a[31:6], 6'd0};
        off  = int'(a[5:2]);
        @(negedge clk);
        i_ce      = 1'b1;
        i_address = a;
        #1;
        chk({nm, ".valid"}, 32'(o_valid), 32'(exp_hit));
        if (exp_hit) begin
            chk({nm, ".data"}, o_data, mw({a[31:2], 2'b00}));
            chk({nm, ".daddr"}, o_data_addr, a);
        end else begin
            chk({nm, ".ready"}, 32'(o_ready), 32'd1);
        end
        @(posedge clk);
        #1;
        i_ce = 1'b0;
        if (exp_hit) return;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            wa = base + 32'(4 * k);
            if (k == rst_at) begin
                rst         = 1'b1;
                i_mem_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk({nm, ".rst_ready"}, 32'(o_ready), 32'd1);
                chk({nm, ".rst_mval"}, 32'(o_mem_valid), 32'd0);
                chk({nm, ".rst_valid"}, 32'(o_valid), 32'd0);
                return;
            end
            i_mem_valid = 1'b1;
            i_mem_data  = mw(wa);
            i_flush     = (k == flush_at);
            #1;
            chk({nm, ".mval"}, 32'(o_mem_valid), 32'd1);
            chk({nm, ".maddr"}, o_mem_address, wa);
            chk({nm, ".rready"}, 32'(o_ready), 32'd0);
            chk({nm, ".rvalid"}, 32'(o_valid), 32'(k == off));
            if (k == off) begin
                chk({nm, ".rdata"}, o_data, mw(wa));
                chk({nm, ".rdaddr"}, o_data_addr, a);
            end
        end
        @(negedge clk);
        i_mem_valid = 1'b0;
        i_flush     = 1'b0;
        #1;
        chk({nm, ".done_ready"}, 32'(o_ready), 32'd1);
        chk({nm, ".done_mval"}, 32'(o_mem_valid), 32'd0);
    endtask

    task automatic count_low(input string nm);
        int n;
        n = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            #1;
            if (o_ready) break;
            n++;
        end
        chk(nm, 32'(n), 32'd128);
    endtask

    initial begin
        rst         = 1'b1;
        stall       = 1'b0;
        i_ce        = 1'b0;
        i_address   = '0;
        i_flush     = 1'b0;
        i_mem_valid = 1'b0;
        i_mem_data  = '0;

        vecs[0]  = '{32'h0000_0048, 1'b0, "cold48"};
        vecs[1]  = '{32'h0000_0048, 1'b1, "hit48"};
        vecs[2]  = '{32'h0000_007C, 1'b1, "hit7c"};
        vecs[3]  = '{32'h0000_0040, 1'b1, "hit40"};
        vecs[4]  = '{32'h0000_00C4, 1'b0, "missA"};
        vecs[5]  = '{32'h0000_20C8, 1'b0, "missB"};
        vecs[6]  = '{32'h0000_00C4, 1'b1, "hitA"};
        vecs[7]  = '{32'h0000_20C8, 1'b1, "hitB"};
        vecs[8]  = '{32'h0000_40CC, 1'b0, "missC"};
        vecs[9]  = '{32'h0000_20C8, 1'b1, "hitB2"};
        vecs[10] = '{32'h0000_40CC, 1'b1, "hitC"};
        vecs[11] = '{32'h0000_60D0, 1'b0, "missD"};
        vecs[12] = '{32'h0000_40CC, 1'b1, "hitC2"};
        vecs[13] = '{32'h0000_60D0, 1'b1, "hitD"};
        vecs[14] = '{32'h0000_00C4, 1'b0, "missA2"};
        vecs[15] = '{32'h0000_60D0, 1'b1, "hitD2"};
        vecs[16] = '{32'h0000_40CC, 1'b0, "missC2"};
        vecs[17] = '{32'h0000_00C4, 1'b1, "hitA2"};
        vecs[18] = '{32'h0000_0048, 1'b1, "hit48b"};

        repeat (3) @(negedge clk);
        #1;
        chk("reset.ready", 32'(o_ready), 32'd1);
        chk("reset.valid", 32'(o_valid), 32'd0);
        chk("reset.mval", 32'(o_mem_valid), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) begin
            fetch(vecs[i].addr, vecs[i].hit, -1, -1, vecs[i].name);
        end

        // Stalled requests: nothing happens, even for a hit address.
        @(negedge clk);
        i_ce      = 1'b1;
        stall     = 1'b1;
        i_address = 32'h0000_1000;
        #1;
        chk("stall.valid", 32'(o_valid), 32'd0);
        chk("stall.mval", 32'(o_mem_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("stall.ready", 32'(o_ready), 32'd1);
        chk("stall.mval2", 32'(o_mem_valid), 32'd0);
        i_address = 32'h0000_0048;
        #1;
        chk("stall.hitvalid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        i_ce  = 1'b0;
        stall = 1'b0;
        fetch(32'h0000_1000, 1'b0, -1, -1, "post_stall");
        fetch(32'h0000_1000, 1'b1, -1, -1, "post_stall_hit");

        // Flush alongside a hit request.
        @(negedge clk);
        i_ce      = 1'b1;
        i_address = 32'h0000_0048;
        i_flush   = 1'b1;
        #1;
        chk("flush.valid", 32'(o_valid), 32'd0);
        @(posedge clk);
        #1;
        i_ce    = 1'b0;
        i_flush = 1'b0;
        count_low("flush.len");
        fetch(32'h0000_0048, 1'b0, -1, -1, "flush.miss48");
        fetch(32'h0000_1000, 1'b0, -1, -1, "flush.miss1000");

        // Flush raised mid-refill runs once the line is in.
        fetch(32'h0000_2048, 1'b0, 3, -1, "fl_refill");
        count_low("fl_refill.len");
        fetch(32'h0000_0048, 1'b0, -1, -1, "fl_refill.m48");
        fetch(32'h0000_2048, 1'b0, -1, -1, "fl_refill.m2048");
        fetch(32'h0000_0048, 1'b1, -1, -1, "fl_refill.h48");
        fetch(32'h0000_2050, 1'b1, -1, -1, "fl_refill.h2050");

        // Reset during a refill abandons it.
        fetch(32'h0000_4048, 1'b0, -1, 5, "rst_mid");
        fetch(32'h0000_4048, 1'b0, -1, -1, "rst_mid.again");
        fetch(32'h0000_4048, 1'b1, -1, -1, "rst_mid.hit");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
